// File: rtl/countdown_ctrl.sv
// MM:SS countdown controller: tick extraction, button debounce, run/pause/done
// sequencing with BCD countdown, alarm gating and a 4-digit multiplexed display scan.
module countdown_ctrl #(
  parameter int DEB_SAMPLES  = 4,
  parameter int DONE_SECONDS = 10
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       clk_1hz,
  input  logic       clk_500hz,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic [7:0] preset_mm,
  input  logic [7:0] preset_ss,
  output logic [2:0] state,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic       done,
  output logic       buzzer,
  output logic [3:0] seg_sel,
  output logic [3:0] seg_digit
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] PAUSE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;

  localparam int             DCW       = $clog2(DEB_SAMPLES + 1);
  localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_SAMPLES - 1);
  localparam logic [7:0]     DONE_LAST = 8'(DONE_SECONDS - 1);

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
    return (d > max_d) ? max_d : d;
  endfunction

  // Decrement {mm,ss} by one second with BCD borrows; caller guarantees t != 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else if (t[7:4] != 4'd0) begin
      r[7:4] = t[7:4] - 4'd1;
      r[3:0] = 4'd9;
    end else begin
      r[7:0] = 8'h59;
      if (t[11:8] != 4'd0) begin
        r[11:8] = t[11:8] - 4'd1;
      end else begin
        r[11:8]  = 4'd9;
        r[15:12] = t[15:12] - 4'd1;
      end
    end
    return r;
  endfunction

  logic        clk_1hz_d, clk_500hz_d;
  logic        sec_tick, scan_tick;
  logic [2:0]  btn_raw, btn_meta, btn_sync, btn_level, press;
  logic [DCW-1:0] deb_cnt [3];
  logic [15:0] preset_s, count_r, count_n, disp_s, disp_r;
  logic [2:0]  state_r, state_n;
  logic [7:0]  done_cnt_r, done_cnt_n;
  logic [1:0]  idx_r, idx_n;
  logic [3:0]  sel_n, digit_n, seg_sel_r, seg_digit_r;
  logic        done_r, buzzer_r;
  logic        start_p, pause_p, clear_p;

  // Delay registers reset high so a level already high at reset release is not a tick.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      clk_1hz_d   <= 1'b1;
      clk_500hz_d <= 1'b1;
    end else begin
      clk_1hz_d   <= clk_1hz;
      clk_500hz_d <= clk_500hz;
    end
  end

  assign sec_tick  = clk_1hz & ~clk_1hz_d;
  assign scan_tick = clk_500hz & ~clk_500hz_d;
  assign btn_raw   = {btn_clear, btn_pause, btn_start};

  // Synchronise raw buttons, then accept a new level after DEB_SAMPLES agreeing samples.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta  <= 3'b000;
      btn_sync  <= 3'b000;
      btn_level <= 3'b000;
      press     <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= {DCW{1'b0}};
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      press    <= 3'b000;
      if (scan_tick) begin
        for (int i = 0; i < 3; i++) begin
          if (btn_sync[i] == btn_level[i]) begin
            deb_cnt[i] <= {DCW{1'b0}};
          end else if (deb_cnt[i] == DEB_LAST) begin
            deb_cnt[i]   <= {DCW{1'b0}};
            btn_level[i] <= btn_sync[i];
            press[i]     <= btn_sync[i];
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DCW'(1);
          end
        end
      end
    end
  end

  assign start_p  = press[0];
  assign pause_p  = press[1];
  assign clear_p  = press[2];
  assign preset_s = {preset_mm[7:4], clamp_digit(preset_mm[3:0], 4'd9),
                     clamp_digit(preset_ss[7:4], 4'd5), clamp_digit(preset_ss[3:0], 4'd9)};

  // Next-state logic; priority is clear over pause over start in every state.
  always_comb begin
    state_n    = state_r;
    count_n    = count_r;
    done_cnt_n = 8'd0;
    case (state_r)
      IDLE: begin
        count_n = 16'h0000;
        if (!clear_p && !pause_p && start_p && (preset_s != 16'h0000)) begin
          state_n = RUN;
          count_n = preset_s;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (clear_p) begin
          state_n = IDLE;
          count_n = 16'h0000;
        end else if (sec_tick) begin
          count_n = bcd_dec(count_r);
          if (bcd_dec(count_r) == 16'h0000) state_n = DONE;
          else if (pause_p)                 state_n = PAUSE;
          else                              state_n = RUN;
        end else if (pause_p) begin
          state_n = PAUSE;
        end else begin
          state_n = RUN;
        end
      end
      PAUSE: begin
        if (clear_p) begin
          state_n = IDLE;
          count_n = 16'h0000;
        end else if (pause_p) begin
          state_n = PAUSE;
        end else if (start_p) begin
          state_n = RUN;
        end else begin
          state_n = PAUSE;
        end
      end
      DONE: begin
        count_n    = 16'h0000;
        done_cnt_n = done_cnt_r;
        if (clear_p || (start_p && !pause_p)) begin
          state_n = IDLE;
        end else if (sec_tick) begin
          if (done_cnt_r == DONE_LAST) begin
            state_n = IDLE;
          end else begin
            done_cnt_n = done_cnt_r + 8'd1;
          end
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = 16'h0000;
      end
    endcase
  end

  assign disp_s = (state_n == IDLE) ? preset_s : count_n;
  assign idx_n  = scan_tick ? (idx_r + 2'd1) : idx_r;

  // Digit select and value are derived from the same next index so they change together.
  always_comb begin
    case (idx_n)
      2'd0:    begin sel_n = 4'b1110; digit_n = disp_s[3:0];   end
      2'd1:    begin sel_n = 4'b1101; digit_n = disp_s[7:4];   end
      2'd2:    begin sel_n = 4'b1011; digit_n = disp_s[11:8];  end
      2'd3:    begin sel_n = 4'b0111; digit_n = disp_s[15:12]; end
      default: begin sel_n = 4'b1110; digit_n = 4'd0;          end
    endcase
  end

  // Main state, count and registered outputs.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= 16'h0000;
      done_cnt_r  <= 8'd0;
      disp_r      <= 16'h0000;
      idx_r       <= 2'd0;
      seg_sel_r   <= 4'b1110;
      seg_digit_r <= 4'd0;
      done_r      <= 1'b0;
      buzzer_r    <= 1'b0;
    end else begin
      state_r     <= state_n;
      count_r     <= count_n;
      done_cnt_r  <= done_cnt_n;
      disp_r      <= disp_s;
      idx_r       <= idx_n;
      seg_sel_r   <= sel_n;
      seg_digit_r <= digit_n;
      done_r      <= (state_n == DONE);
      buzzer_r    <= (state_n == DONE) & clk_500hz;
    end
  end

  assign state     = state_r;
  assign mm_bcd    = disp_r[15:8];
  assign ss_bcd    = disp_r[7:0];
  assign done      = done_r;
  assign buzzer    = buzzer_r;
  assign seg_sel   = seg_sel_r;
  assign seg_digit = seg_digit_r;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl: drives the 1 Hz / 500 Hz levels directly with short
// pulses and compares every output against hand-computed values.
module tb_countdown_ctrl;

  logic       clk_50m = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_1hz = 1'b1;
  logic       clk_500hz = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_clear = 1'b0;
  logic [7:0] preset_mm = 8'h12;
  logic [7:0] preset_ss = 8'h34;
  logic [2:0] state;
  logic [7:0] mm_bcd, ss_bcd;
  logic       done, buzzer;
  logic [3:0] seg_sel, seg_digit;

  int n_checks = 0;
  int n_fail = 0;

  countdown_ctrl #(.DEB_SAMPLES(4), .DONE_SECONDS(10)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .clk_1hz(clk_1hz), .clk_500hz(clk_500hz),
    .btn_start(btn_start), .btn_pause(btn_pause), .btn_clear(btn_clear),
    .preset_mm(preset_mm), .preset_ss(preset_ss), .state(state),
    .mm_bcd(mm_bcd), .ss_bcd(ss_bcd), .done(done), .buzzer(buzzer),
    .seg_sel(seg_sel), .seg_digit(seg_digit)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       btn_start = v;
      1:       btn_pause = v;
      default: btn_clear = v;
    endcase
  endtask

  // Each scan pulse gives one scan_tick on the first posedge after it starts.
  task automatic scan(input int n);
    repeat (n) begin
      clk_500hz = 1'b1;
      cycles(2);
      clk_500hz = 1'b0;
      cycles(2);
    end
  endtask

  task automatic sec(input int n);
    repeat (n) begin
      clk_1hz = 1'b1;
      cycles(2);
      clk_1hz = 1'b0;
      cycles(2);
    end
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    scan(6);
    set_btn(which, 1'b0);
    scan(6);
  endtask

  // The press pulse is acted on one cycle after the accepting scan_tick; line sec_tick up with it.
  task automatic press_with_sec(input int which);
    set_btn(which, 1'b1);
    scan(4);
    clk_500hz = 1'b1;
    cycles(1);
    clk_1hz = 1'b1;
    cycles(1);
    clk_500hz = 1'b0;
    cycles(1);
    clk_1hz = 1'b0;
    cycles(2);
    set_btn(which, 1'b0);
    scan(6);
  endtask

  initial begin
    // T1: reset values, no ticks from levels already high at release, scan sequence
    cycles(3);
    check("rst_state", state, 3'd0);
    check("rst_disp", {mm_bcd, ss_bcd}, 16'h0000);
    check("rst_seg_sel", seg_sel, 4'b1110);
    check("rst_seg_digit", seg_digit, 4'd0);
    check("rst_done_buzzer", {done, buzzer}, 2'b00);
    rst_n = 1'b1;
    cycles(3);
    check("post_rst_seg_sel", seg_sel, 4'b1110);
    check("post_rst_disp", {mm_bcd, ss_bcd}, 16'h1234);
    check("post_rst_state", state, 3'd0);
    clk_500hz = 1'b0;
    clk_1hz = 1'b0;
    cycles(2);
    scan(1);
    check("scan1", {seg_sel, seg_digit}, {4'b1101, 4'd3});
    scan(1);
    check("scan2", {seg_sel, seg_digit}, {4'b1011, 4'd2});
    scan(1);
    check("scan3", {seg_sel, seg_digit}, {4'b0111, 4'd1});
    scan(1);
    check("scan_wrap", {seg_sel, seg_digit}, {4'b1110, 4'd4});

    // T2: 01:02 countdown through the minute borrow to DONE, buzzer gating
    preset_mm = 8'h01; preset_ss = 8'h02;
    cycles(1);
    check("t2_idle_disp", {mm_bcd, ss_bcd}, 16'h0102);
    press(0);
    check("t2_run", state, 3'd1);
    check("t2_loaded", {mm_bcd, ss_bcd}, 16'h0102);
    sec(1);
    check("t2_0101", {mm_bcd, ss_bcd}, 16'h0101);
    sec(1);
    check("t2_0100", {mm_bcd, ss_bcd}, 16'h0100);
    sec(1);
    check("t2_0059", {mm_bcd, ss_bcd}, 16'h0059);
    sec(58);
    check("t2_0001", {state, 8'h00, mm_bcd, ss_bcd}, {3'd1, 8'h00, 16'h0001});
    sec(1);
    check("t2_done_state", state, 3'd3);
    check("t2_done_flag", done, 1'b1);
    check("t2_done_disp", {mm_bcd, ss_bcd}, 16'h0000);
    clk_500hz = 1'b1;
    cycles(2);
    check("t2_buzz_hi", buzzer, 1'b1);
    clk_500hz = 1'b0;
    cycles(2);
    check("t2_buzz_lo", buzzer, 1'b0);

    // T6: DONE returns to IDLE after exactly 10 sec_ticks
    sec(9);
    check("t6_still_done", state, 3'd3);
    sec(1);
    check("t6_idle", {state, done}, {3'd0, 1'b0});

    // T3: pause holds the count, start resumes
    preset_mm = 8'h00; preset_ss = 8'h05;
    press(0);
    check("t3_run", {state, 8'h00, mm_bcd, ss_bcd}, {3'd1, 8'h00, 16'h0005});
    press(1);
    check("t3_pause", state, 3'd2);
    sec(3);
    check("t3_held", {state, 8'h00, mm_bcd, ss_bcd}, {3'd2, 8'h00, 16'h0005});
    press(0);
    check("t3_resume", state, 3'd1);
    sec(1);
    check("t3_0004", {mm_bcd, ss_bcd}, 16'h0004);
    press(2);
    check("t3_clear", state, 3'd0);

    // T4: button and sec_tick on the same cycle
    preset_mm = 8'h00; preset_ss = 8'h10;
    press(0);
    check("t4_run10", {state, 8'h00, mm_bcd, ss_bcd}, {3'd1, 8'h00, 16'h0010});
    press_with_sec(2);
    check("t4_clear_sec", state, 3'd0);
    preset_ss = 8'h03;
    press(0);
    press_with_sec(1);
    check("t4_pause_sec", {state, 8'h00, mm_bcd, ss_bcd}, {3'd2, 8'h00, 16'h0002});
    press(2);
    preset_ss = 8'h01;
    press(0);
    press_with_sec(1);
    check("t4_pause_sec_done", {state, 8'h00, mm_bcd, ss_bcd}, {3'd3, 8'h00, 16'h0000});
    press(2);
    check("t4_done_clear", state, 3'd0);

    // T5: bounce rejection, held button, zero preset, sanitising
    preset_ss = 8'h03;
    for (int k = 1; k <= 3; k++) begin
      set_btn(0, 1'b1);
      scan(k);
      set_btn(0, 1'b0);
      scan(5);
      check($sformatf("t5_bounce%0d", k), state, 3'd0);
    end
    preset_ss = 8'h01;
    press(0);
    sec(1);
    check("t5_done", state, 3'd3);
    set_btn(0, 1'b1);
    scan(20);
    check("t5_hold_once", state, 3'd0);
    set_btn(0, 1'b0);
    scan(6);
    check("t5_release", state, 3'd0);
    preset_ss = 8'h00;
    press(0);
    check("t5_zero_preset", state, 3'd0);
    preset_mm = 8'h1C; preset_ss = 8'h7F;
    cycles(1);
    check("t5_sanitise", {mm_bcd, ss_bcd}, 16'h1959);
    press(0);
    sec(1);
    check("t5_san_run", {state, 8'h00, mm_bcd, ss_bcd}, {3'd1, 8'h00, 16'h1958});

    // Mid-count reset aborts immediately
    @(negedge clk_50m);
    rst_n = 1'b0;
    #1;
    check("abort_state", state, 3'd0);
    check("abort_disp", {mm_bcd, ss_bcd}, 16'h0000);
    check("abort_seg", {seg_sel, seg_digit}, {4'b1110, 4'd0});
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    check("abort_recover", state, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
